descriptor_send_q: RTL and testbench

- Parametrised successor of the frame-parser descriptor sender.
- Pairs each parsed descriptor with the packet buffer ID allocated for that frame and overwrites the descriptor's low BUFID_W bits with that ID. Also acknowledges the ID back to the allocator and forwards the descriptor downstream under a wr/ack handshake.
- Adds a descriptor FIFO so the parser is not stalled by a slow acker, an ack timeout with buffer-ID release, and saturating discard/timeout statistics.

---
 rtl/descriptor_send_q_if.sv | 40 ++++
 rtl/descriptor_send_q.sv | 165 ++++++++++++++++
 tb/tb_descriptor_send_q.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/descriptor_send_q_if.sv
// Bus bundle for descriptor_send_q: parser/allocator ingress, downstream egress, status.
// The slave modport is the sender's view; master is the surrounding logic's view.
interface descriptor_send_q_if #(
  parameter int unsigned DESC_W  = 72,
  parameter int unsigned BUFID_W = 9,
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned CNT_W   = 16
);
  logic               i_descriptor_valid;
  logic [DESC_W-1:0]  iv_descriptor;
  logic               i_pkt_bufid_wr;
  logic [BUFID_W-1:0] iv_pkt_bufid;
  logic               o_pkt_bufid_ack;
  logic               o_pkt_bufid_wr;
  logic [BUFID_W-1:0] ov_pkt_bufid;
  logic               o_descriptor_wr;
  logic [DESC_W-1:0]  ov_descriptor;
  logic               i_descriptor_ack;
  logic               o_bufid_release;
  logic [BUFID_W-1:0] ov_release_bufid;
  logic [FIFO_AW:0]   ov_fifo_used;
  logic               o_fifo_full;
  logic [CNT_W-1:0]   ov_discard_cnt;
  logic [CNT_W-1:0]   ov_timeout_cnt;
  logic [1:0]         ov_send_state;

  modport slave (
    input  i_descriptor_valid, iv_descriptor, i_pkt_bufid_wr, iv_pkt_bufid, i_descriptor_ack,
    output o_pkt_bufid_ack, o_pkt_bufid_wr, ov_pkt_bufid, o_descriptor_wr, ov_descriptor,
    output o_bufid_release, ov_release_bufid, ov_fifo_used, o_fifo_full,
    output ov_discard_cnt, ov_timeout_cnt, ov_send_state
  );

  modport master (
    output i_descriptor_valid, iv_descriptor, i_pkt_bufid_wr, iv_pkt_bufid, i_descriptor_ack,
    input  o_pkt_bufid_ack, o_pkt_bufid_wr, ov_pkt_bufid, o_descriptor_wr, ov_descriptor,
    input  o_bufid_release, ov_release_bufid, ov_fifo_used, o_fifo_full,
    input  ov_discard_cnt, ov_timeout_cnt, ov_send_state
  );
endinterface

// File: rtl/descriptor_send_q.sv
// Descriptor sender: merges each descriptor with its buffer ID, queues it in a small FIFO
// and hands it downstream under wr/ack, releasing the buffer ID if the ack never comes.
module descriptor_send_q #(
  parameter int unsigned DESC_W      = 72,
  parameter int unsigned BUFID_W     = 9,
  parameter int unsigned FIFO_AW     = 2,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned CNT_W       = 16
) (
  input logic                  clk_sys,
  input logic                  reset_n,
  descriptor_send_q_if.slave   bus_io
);
  localparam int unsigned Depth      = 2 ** FIFO_AW;
  localparam int unsigned TmrW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned TmoLastInt = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
  localparam logic [TmrW-1:0] TmoLast = TmrW'(TmoLastInt);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWaitAck = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [DESC_W-1:0]  mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   used_q, used_d;
  logic               full_q;
  logic               push, pop, discard;

  logic               pulse_q;
  logic [BUFID_W-1:0] pkt_bufid_q;
  logic [DESC_W-1:0]  desc_q, desc_d;
  logic               desc_wr_q, desc_wr_d;
  logic [TmrW-1:0]    timer_q, timer_d;
  logic               release_q, release_d;
  logic [BUFID_W-1:0] release_id_q, release_id_d;
  logic               timeout_inc;
  logic [CNT_W-1:0]   discard_cnt_q, timeout_cnt_q;

  // Fullness is the occupancy at the start of the cycle; a same-cycle pop cannot rescue a push.
  assign push    = bus_io.i_descriptor_valid & bus_io.i_pkt_bufid_wr & ~full_q;
  assign discard = bus_io.i_descriptor_valid & ~push;

  always_comb begin
    used_d = used_q;
    unique case ({push, pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus_io.iv_descriptor[DESC_W-1:BUFID_W], bus_io.iv_pkt_bufid};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      full_q      <= 1'b0;
      pulse_q     <= 1'b0;
      pkt_bufid_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      used_q      <= used_d;
      full_q      <= (used_d == (FIFO_AW + 1)'(Depth));
      pulse_q     <= push;
      pkt_bufid_q <= push ? bus_io.iv_pkt_bufid : '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    desc_wr_d    = desc_wr_q;
    timer_d      = timer_q;
    release_d    = 1'b0;
    release_id_d = '0;
    timeout_inc  = 1'b0;
    pop          = 1'b0;
    case (state_q)
      StIdle: begin
        desc_d    = '0;
        desc_wr_d = 1'b0;
        if (used_q != '0) begin
          pop       = 1'b1;
          desc_d    = mem_q[rd_ptr_q];
          desc_wr_d = 1'b1;
          timer_d   = '0;
          state_d   = StWaitAck;
        end
      end
      StWaitAck: begin
        timer_d = timer_q + 1'b1;
        // Ack takes priority over a simultaneous timeout expiry.
        if (bus_io.i_descriptor_ack) begin
          desc_d    = '0;
          desc_wr_d = 1'b0;
          state_d   = StIdle;
        end else if ((ACK_TIMEOUT != 0) && (timer_q == TmoLast)) begin
          desc_d       = '0;
          desc_wr_d    = 1'b0;
          release_d    = 1'b1;
          release_id_d = desc_q[BUFID_W-1:0];
          timeout_inc  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        desc_d    = '0;
        desc_wr_d = 1'b0;
        timer_d   = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      desc_q       <= '0;
      desc_wr_q    <= 1'b0;
      timer_q      <= '0;
      release_q    <= 1'b0;
      release_id_q <= '0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      desc_wr_q    <= desc_wr_d;
      timer_q      <= timer_d;
      release_q    <= release_d;
      release_id_q <= release_id_d;
    end
  end

  // Statistics saturate at all-ones.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      discard_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (discard && (discard_cnt_q != '1))     discard_cnt_q <= discard_cnt_q + 1'b1;
      if (timeout_inc && (timeout_cnt_q != '1)) timeout_cnt_q <= timeout_cnt_q + 1'b1;
    end
  end

  assign bus_io.o_pkt_bufid_ack  = pulse_q;
  assign bus_io.o_pkt_bufid_wr   = pulse_q;
  assign bus_io.ov_pkt_bufid     = pkt_bufid_q;
  assign bus_io.o_descriptor_wr  = desc_wr_q;
  assign bus_io.ov_descriptor    = desc_q;
  assign bus_io.o_bufid_release  = release_q;
  assign bus_io.ov_release_bufid = release_id_q;
  assign bus_io.ov_fifo_used     = used_q;
  assign bus_io.o_fifo_full      = full_q;
  assign bus_io.ov_discard_cnt   = discard_cnt_q;
  assign bus_io.ov_timeout_cnt   = timeout_cnt_q;
  assign bus_io.ov_send_state    = state_q;
endmodule

// File: tb/tb_descriptor_send_q.sv
// Scoreboard bench for descriptor_send_q: directed scenarios plus random traffic, with a
// queue-based reference model and a monitor that checks every cycle.
module tb_descriptor_send_q;
  localparam int unsigned DESC_W  = 72;
  localparam int unsigned BUFID_W = 9;
  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned TMO     = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int          CW      = DESC_W + 8;

  logic clk_sys;
  logic reset_n;

  descriptor_send_q_if #(
    .DESC_W (DESC_W),
    .BUFID_W(BUFID_W),
    .FIFO_AW(FIFO_AW),
    .CNT_W  (CNT_W)
  ) bus ();

  descriptor_send_q #(
    .DESC_W     (DESC_W),
    .BUFID_W    (BUFID_W),
    .FIFO_AW    (FIFO_AW),
    .ACK_TIMEOUT(TMO),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DESC_W-1:0]  exp_desc_q [$];
  int                 m_discard = 0;
  int                 m_timeout = 0;
  bit                 pend_valid = 1'b0;
  logic [BUFID_W-1:0] pend_id = '0;
  bit                 exp_wr = 1'b0;
  int                 hold_cnt = 0;
  int                 prev_occ = 0;
  logic [DESC_W-1:0]  cur_desc = '0;
  int                 n_release = 0;
  bit                 mon_en = 1'b0;
  int                 ack_mode = 0;
  int                 ack_at = 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each edge and checks against the model.
  bit                 ack_e, rel_exp;
  logic [BUFID_W-1:0] rel_id, pend_eff;
  logic [DESC_W:0]    exp_out;
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      if (!mon_en) begin
        exp_wr   = 1'b0;
        hold_cnt = 0;
        prev_occ = 0;
        m_timeout = 0;
        exp_desc_q.delete();
      end else begin
        ack_e    = bus.i_descriptor_ack;
        rel_exp  = 1'b0;
        rel_id   = '0;
        pend_eff = pend_valid ? pend_id : '0;
        check("bufid_pulse", CW'({bus.o_pkt_bufid_wr, bus.o_pkt_bufid_ack, bus.ov_pkt_bufid}),
              CW'({pend_valid, pend_valid, pend_eff}));
        if (bus.o_bufid_release) n_release++;
        if (exp_wr) begin
          if (ack_e) begin
            exp_wr = 1'b0;
          end else if (hold_cnt == int'(TMO)) begin
            exp_wr  = 1'b0;
            rel_exp = 1'b1;
            rel_id  = cur_desc[BUFID_W-1:0];
            m_timeout++;
          end else begin
            hold_cnt++;
          end
        end else if (prev_occ > 0) begin
          cur_desc = exp_desc_q.pop_front();
          exp_wr   = 1'b1;
          hold_cnt = 1;
        end
        if (exp_wr) exp_out = {1'b1, cur_desc};
        else        exp_out = '0;
        check("desc_out", CW'({bus.o_descriptor_wr, bus.ov_descriptor}), CW'(exp_out));
        check("release", CW'({bus.o_bufid_release, bus.ov_release_bufid}), CW'({rel_exp, rel_id}));
        check("send_state", CW'(bus.ov_send_state), exp_wr ? CW'(2) : CW'(0));
        check("fifo_used", CW'(bus.ov_fifo_used), CW'(exp_desc_q.size()));
        check("fifo_full", CW'(bus.o_fifo_full), CW'(exp_desc_q.size() == int'(DEPTH)));
        check("discard_cnt", CW'(bus.ov_discard_cnt), CW'(m_discard));
        check("timeout_cnt", CW'(bus.ov_timeout_cnt), CW'(m_timeout));
        prev_occ = exp_desc_q.size();
      end
    end
  end

  // Drives inputs for the next edge and records what the model expects from them.
  task automatic step(input bit v, input bit bw, input logic [DESC_W-1:0] d,
                      input logic [BUFID_W-1:0] b);
    bit a;
    @(posedge clk_sys);
    #2;
    case (ack_mode)
      0:       a = 1'b0;
      1:       a = ($urandom_range(0, 2) == 0);
      default: a = exp_wr && (hold_cnt >= ack_at);
    endcase
    bus.i_descriptor_ack   = a;
    bus.i_descriptor_valid = v;
    bus.i_pkt_bufid_wr     = bw;
    bus.iv_descriptor      = d;
    bus.iv_pkt_bufid       = b;
    pend_valid = v && bw && (exp_desc_q.size() < int'(DEPTH));
    pend_id    = b;
    if (pend_valid)  exp_desc_q.push_back({d[DESC_W-1:BUFID_W], b});
    else if (v)      m_discard++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic random_phase(input int n);
    logic [95:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom, $urandom, $urandom};
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, r[DESC_W-1:0],
           r[95:95-BUFID_W+1]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"}, CW'(bus.o_descriptor_wr), '0);
    check({tag, "_desc"}, CW'(bus.ov_descriptor), '0);
    check({tag, "_used"}, CW'(bus.ov_fifo_used), '0);
    check({tag, "_full"}, CW'(bus.o_fifo_full), '0);
    check({tag, "_discard"}, CW'(bus.ov_discard_cnt), '0);
    check({tag, "_timeout"}, CW'(bus.ov_timeout_cnt), '0);
    check({tag, "_state"}, CW'(bus.ov_send_state), '0);
    check({tag, "_release"}, CW'({bus.o_bufid_release, bus.ov_release_bufid}), '0);
    check({tag, "_bufid"}, CW'({bus.o_pkt_bufid_ack, bus.o_pkt_bufid_wr, bus.ov_pkt_bufid}), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n                = 1'b0;
    bus.i_descriptor_valid = 1'b0;
    bus.iv_descriptor      = '0;
    bus.i_pkt_bufid_wr     = 1'b0;
    bus.iv_pkt_bufid       = '0;
    bus.i_descriptor_ack   = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    check_all_zero("reset");
    #4;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single pair, acked 3 cycles into the handshake.
    ack_mode = 2;
    ack_at   = 3;
    step(1'b1, 1'b1, 72'hAA_0123_4567_89AB_C1FF, 9'h005);
    idle(8);

    // Descriptor without buffer ID is discarded.
    step(1'b1, 1'b0, 72'h55_FEDC_BA98_7654_3210, 9'h0AA);
    idle(3);
    check("missing_bufid_discard", CW'(bus.ov_discard_cnt), CW'(1));

    // Backpressure: one in flight, four queued, sixth discarded.
    ack_mode = 0;
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, {8'h10 + 8'(i), 64'h0}, 9'(i));
    idle(1);
    check("bp_full", CW'(bus.o_fifo_full), CW'(1));
    check("bp_used", CW'(bus.ov_fifo_used), CW'(4));
    check("bp_discard", CW'(bus.ov_discard_cnt), CW'(2));
    ack_mode = 2;
    ack_at   = 1;
    idle(14);
    check("bp_drained", CW'(bus.ov_fifo_used), CW'(0));

    // Ack never arrives: release after 8 cycles.
    ack_mode = 0;
    step(1'b1, 1'b1, 72'h33_0000_0000_0000_0000, 9'h01A);
    idle(12);
    check("tmo_count", CW'(bus.ov_timeout_cnt), CW'(1));
    check("tmo_release_pulses", CW'(n_release), CW'(1));

    // Ack on the expiry cycle wins.
    ack_mode = 2;
    ack_at   = int'(TMO);
    step(1'b1, 1'b1, 72'h44_0000_0000_0000_0000, 9'h0B2);
    idle(12);
    check("coincident_count", CW'(bus.ov_timeout_cnt), CW'(1));
    check("coincident_release_pulses", CW'(n_release), CW'(1));

    ack_mode = 1;
    random_phase(300);

    // Reset while waiting for ack with two entries queued.
    ack_mode = 2;
    ack_at   = 1;
    idle(20);
    ack_mode = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, {8'h70 + 8'(i), 64'h0}, 9'h100 + 9'(i));
    idle(2);
    check("pre_reset_wr", CW'(bus.o_descriptor_wr), CW'(1));
    check("pre_reset_used", CW'(bus.ov_fifo_used), CW'(2));
    #3;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_discard  = 0;
    pend_valid = 1'b0;
    n_release  = 0;
    repeat (2) @(posedge clk_sys);
    #5;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    idle(15);
    check("post_reset_no_release", CW'(n_release), CW'(0));

    ack_mode = 1;
    random_phase(100);
    ack_mode = 2;
    ack_at   = 1;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
